// File: rtl/ttl_gate_array_reg.sv
// rtl/ttl_gate_array_reg.sv - multi-channel 2-input gate with propagation pipeline, glitch filter and open-collector model
module ttl_gate_array_reg #(
    parameter int CHANNELS       = 4,
    parameter int FUNC           = 0,
    parameter int DELAY          = 1,
    parameter int FILTER         = 0,
    parameter int OPEN_COLLECTOR = 0
) (
    input  logic                CLK,
    input  logic                CLR_n,
    input  logic [CHANNELS-1:0] A,
    input  logic [CHANNELS-1:0] B,
    output logic [CHANNELS-1:0] Y,
    output logic [CHANNELS-1:0] Y_DRV,
    output logic [CHANNELS-1:0] CHG
);

    // Reject illegal configurations at elaboration time.
    generate
        if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
            $error("ttl_gate_array_reg: CHANNELS must be 1..32");
        end
        if (FUNC < 0 || FUNC > 5) begin : g_bad_func
            $error("ttl_gate_array_reg: FUNC must be 0..5");
        end
        if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
            $error("ttl_gate_array_reg: DELAY must be 1..16");
        end
        if (FILTER < 0 || FILTER > 15) begin : g_bad_filter
            $error("ttl_gate_array_reg: FILTER must be 0..15");
        end
        if (OPEN_COLLECTOR < 0 || OPEN_COLLECTOR > 1) begin : g_bad_oc
            $error("ttl_gate_array_reg: OPEN_COLLECTOR must be 0 or 1");
        end
    endgenerate

    // Reset level is what the gate produces with both inputs low.
    localparam logic                RST_BIT  = (FUNC == 0) || (FUNC == 1) || (FUNC == 5);
    localparam logic [CHANNELS-1:0] RST_VEC  = {CHANNELS{RST_BIT}};
    localparam logic [3:0]          FILT_MAX = 4'(FILTER);

    logic [CHANNELS-1:0] gate_f;
    logic [CHANNELS-1:0] stage [DELAY];
    logic [CHANNELS-1:0] cand;
    logic [3:0]          cnt [CHANNELS];

    // Combinational gate function, applied bitwise to every channel.
    always_comb begin
        case (FUNC)
            0:       gate_f = ~(A & B);
            1:       gate_f = ~(A | B);
            2:       gate_f = A & B;
            3:       gate_f = A | B;
            4:       gate_f = A ^ B;
            5:       gate_f = ~(A ^ B);
            default: gate_f = RST_VEC;
        endcase
    end

    // Propagation delay line: stage 0 samples the gate, later stages shift.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            for (int d = 0; d < DELAY; d++) begin
                stage[d] <= RST_VEC;
            end
        end else begin
            stage[0] <= gate_f;
            for (int d = 1; d < DELAY; d++) begin
                stage[d] <= stage[d-1];
            end
        end
    end

    assign cand = stage[DELAY-1];

    // Glitch filter: a deviation must persist FILTER+1 edges before Y follows it.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            Y   <= RST_VEC;
            CHG <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                CHG[i] <= 1'b0;
                if (cand[i] == Y[i]) begin
                    cnt[i] <= 4'd0;
                end else if (cnt[i] == FILT_MAX) begin
                    Y[i]   <= cand[i];
                    cnt[i] <= 4'd0;
                    CHG[i] <= 1'b1;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    // Open-collector driver sinks whenever the pulled-up line reads low.
    generate
        if (OPEN_COLLECTOR != 0) begin : g_oc
            assign Y_DRV = ~Y;
        end else begin : g_totem
            assign Y_DRV = '0;
        end
    endgenerate

endmodule

// File: tb/tb_ttl_gate_array_reg.sv
// tb/tb_ttl_gate_array_reg.sv - self-checking bench for ttl_gate_array_reg across several configurations
module tb_ttl_gate_array_reg;

    localparam int NI = 7;

    // Configuration table, one entry per instance below.
    int p_ch  [NI] = '{4, 4, 4, 4, 4, 32, 1};
    int p_fn  [NI] = '{0, 4, 0, 0, 2, 5, 1};
    int p_dl  [NI] = '{1, 3, 1, 1, 4, 2, 5};
    int p_flt [NI] = '{0, 0, 2, 0, 0, 3, 1};
    int p_oc  [NI] = '{0, 0, 0, 1, 0, 1, 0};

    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic [31:0] a_v = '0;
    logic [31:0] b_v = '0;

    logic [3:0]  y0, d0, c0, y1, d1, c1, y2, d2, c2, y3, d3, c3, y4, d4, c4;
    logic [31:0] y5, d5, c5;
    logic [0:0]  y6, d6, c6;

    logic [31:0] y_o [NI];
    logic [31:0] d_o [NI];
    logic [31:0] c_o [NI];

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] fh [NI][0:4095];
    logic [31:0] m_y [NI];
    logic [31:0] m_chg [NI];
    int          last_u [NI][32];
    int          e_cnt = 0;

    always #5 clk = ~clk;

    ttl_gate_array_reg #(.CHANNELS(4), .FUNC(0), .DELAY(1), .FILTER(0), .OPEN_COLLECTOR(0)) u0 (
        .CLK(clk), .CLR_n(clr_n), .A(a_v[3:0]), .B(b_v[3:0]), .Y(y0), .Y_DRV(d0), .CHG(c0));
    ttl_gate_array_reg #(.CHANNELS(4), .FUNC(4), .DELAY(3), .FILTER(0), .OPEN_COLLECTOR(0)) u1 (
        .CLK(clk), .CLR_n(clr_n), .A(a_v[3:0]), .B(b_v[3:0]), .Y(y1), .Y_DRV(d1), .CHG(c1));
    ttl_gate_array_reg #(.CHANNELS(4), .FUNC(0), .DELAY(1), .FILTER(2), .OPEN_COLLECTOR(0)) u2 (
        .CLK(clk), .CLR_n(clr_n), .A(a_v[3:0]), .B(b_v[3:0]), .Y(y2), .Y_DRV(d2), .CHG(c2));
    ttl_gate_array_reg #(.CHANNELS(4), .FUNC(0), .DELAY(1), .FILTER(0), .OPEN_COLLECTOR(1)) u3 (
        .CLK(clk), .CLR_n(clr_n), .A(a_v[3:0]), .B(b_v[3:0]), .Y(y3), .Y_DRV(d3), .CHG(c3));
    ttl_gate_array_reg #(.CHANNELS(4), .FUNC(2), .DELAY(4), .FILTER(0), .OPEN_COLLECTOR(0)) u4 (
        .CLK(clk), .CLR_n(clr_n), .A(a_v[3:0]), .B(b_v[3:0]), .Y(y4), .Y_DRV(d4), .CHG(c4));
    ttl_gate_array_reg #(.CHANNELS(32), .FUNC(5), .DELAY(2), .FILTER(3), .OPEN_COLLECTOR(1)) u5 (
        .CLK(clk), .CLR_n(clr_n), .A(a_v), .B(b_v), .Y(y5), .Y_DRV(d5), .CHG(c5));
    ttl_gate_array_reg #(.CHANNELS(1), .FUNC(1), .DELAY(5), .FILTER(1), .OPEN_COLLECTOR(0)) u6 (
        .CLK(clk), .CLR_n(clr_n), .A(a_v[0:0]), .B(b_v[0:0]), .Y(y6), .Y_DRV(d6), .CHG(c6));

    assign y_o[0] = 32'(y0); assign d_o[0] = 32'(d0); assign c_o[0] = 32'(c0);
    assign y_o[1] = 32'(y1); assign d_o[1] = 32'(d1); assign c_o[1] = 32'(c1);
    assign y_o[2] = 32'(y2); assign d_o[2] = 32'(d2); assign c_o[2] = 32'(c2);
    assign y_o[3] = 32'(y3); assign d_o[3] = 32'(d3); assign c_o[3] = 32'(c3);
    assign y_o[4] = 32'(y4); assign d_o[4] = 32'(d4); assign c_o[4] = 32'(c4);
    assign y_o[5] = y5;      assign d_o[5] = d5;      assign c_o[5] = c5;
    assign y_o[6] = 32'(y6); assign d_o[6] = 32'(d6); assign c_o[6] = 32'(c6);

    function automatic logic [31:0] mask_of(input int ch);
        return (ch >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ch) - 32'd1);
    endfunction

    function automatic logic [31:0] gate(input int fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            0: return ~(a & b);
            1: return ~(a | b);
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic logic [31:0] rst_vec(input int k);
        logic [31:0] z;
        z = '0;
        return gate(p_fn[k], z, z) & mask_of(p_ch[k]);
    endfunction

    // Candidate seen at edge e: the gate value sampled DELAY edges earlier, else the reset level.
    function automatic logic [31:0] cand_at(input int k, input int e);
        if (e > p_dl[k]) return fh[k][e - p_dl[k]];
        return rst_vec(k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_cnt = 0;
        for (int k = 0; k < NI; k++) begin
            m_y[k]   = rst_vec(k);
            m_chg[k] = '0;
            for (int c = 0; c < 32; c++) last_u[k][c] = 0;
        end
    endtask

    // Y follows the candidate at edge e when the candidate disagreed with Y on
    // each of the last FILTER+1 edges, all of them after the previous update/reset.
    task automatic model_step();
        e_cnt++;
        for (int k = 0; k < NI; k++) begin
            logic [31:0] ny;
            logic [31:0] nc;
            fh[k][e_cnt] = gate(p_fn[k], a_v, b_v) & mask_of(p_ch[k]);
            ny = m_y[k];
            nc = '0;
            for (int c = 0; c < p_ch[k]; c++) begin
                bit upd;
                upd = 1'b1;
                for (int j = 0; j <= p_flt[k]; j++) begin
                    logic [31:0] cv;
                    if (e_cnt - j <= last_u[k][c]) begin
                        upd = 1'b0;
                    end else begin
                        cv = cand_at(k, e_cnt - j);
                        if (cv[c] == m_y[k][c]) upd = 1'b0;
                    end
                end
                if (upd) begin
                    logic [31:0] cv0;
                    cv0 = cand_at(k, e_cnt);
                    ny[c] = cv0[c];
                    nc[c] = 1'b1;
                    last_u[k][c] = e_cnt;
                end
            end
            m_y[k]   = ny;
            m_chg[k] = nc;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NI; k++) begin
            logic [31:0] ed;
            ed = (p_oc[k] != 0) ? (~m_y[k] & mask_of(p_ch[k])) : 32'h0;
            chk($sformatf("%s_y%0d", tag, k), y_o[k], m_y[k]);
            chk($sformatf("%s_chg%0d", tag, k), c_o[k], m_chg[k]);
            chk($sformatf("%s_drv%0d", tag, k), d_o[k], ed);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (clr_n) model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        model_reset();

        // Defaults: NAND, A=B=F -> Y falls to 0 at edge 2 with a one-cycle CHG
        do_reset();
        a_v = 32'hF; b_v = 32'hF;
        chk("d_y_reset", y_o[0], 32'hF);
        tick("d1");
        chk("d_y_e1", y_o[0], 32'hF);
        chk("d_chg_e1", c_o[0], 32'h0);
        tick("d2");
        chk("d_y_e2", y_o[0], 32'h0);
        chk("d_chg_e2", c_o[0], 32'hF);
        tick("d3");
        chk("d_chg_e3", c_o[0], 32'h0);

        // XOR with DELAY=3: result first visible at edge 4
        do_reset();
        a_v = 32'h5; b_v = 32'h3;
        for (int n = 1; n <= 3; n++) begin
            tick("x");
            chk("xor_y_early", y_o[1], 32'h0);
        end
        tick("x4");
        chk("xor_y_e4", y_o[1], 32'h6);
        chk("xor_chg_e4", c_o[1], 32'h6);
        tick("x5");
        chk("xor_chg_e5", c_o[1], 32'h0);

        // FILTER=2: a two-cycle deviation is swallowed
        do_reset();
        a_v = 32'h1; b_v = 32'h1;
        tick("g"); tick("g");
        a_v = 32'h0;
        for (int n = 0; n < 5; n++) begin
            tick("g");
            chk("glitch_y0", {31'b0, y_o[2][0]}, 32'h1);
            chk("glitch_chg0", {31'b0, c_o[2][0]}, 32'h0);
        end

        // FILTER=2: a three-cycle deviation passes at edge 4
        do_reset();
        a_v = 32'h1; b_v = 32'h1;
        for (int n = 1; n <= 3; n++) begin
            tick("p");
            chk("pass_y0_early", {31'b0, y_o[2][0]}, 32'h1);
        end
        a_v = 32'h0;
        tick("p4");
        chk("pass_y0_e4", {31'b0, y_o[2][0]}, 32'h0);
        chk("pass_chg0_e4", {31'b0, c_o[2][0]}, 32'h1);

        // Open collector: NAND of 1001 sinks on channels 0 and 3
        do_reset();
        a_v = 32'h9; b_v = 32'h9;
        tick("o1");
        chk("oc_y_e1", y_o[3], 32'hF);
        chk("oc_drv_e1", d_o[3], 32'h0);
        tick("o2");
        chk("oc_y_e2", y_o[3], 32'h6);
        chk("oc_drv_e2", d_o[3], 32'h9);

        // DELAY=4: reset mid-flight discards the pipeline contents
        do_reset();
        a_v = 32'hF; b_v = 32'hF;
        tick("r1"); tick("r2");
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        model_reset();
        check_all("rmid");
        tick("r3"); tick("r4");
        @(negedge clk);
        clr_n = 1'b1;
        tick("r5");
        chk("rflush_y_e5", y_o[4], 32'h0);
        chk("rflush_chg_e5", c_o[4], 32'h0);

        // Random traffic with sparse toggles, bursts and occasional async resets
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            if (!clr_n) begin
                clr_n = 1'b1;
            end else if ($urandom_range(0, 99) < 2) begin
                clr_n = 1'b0;
                #1;
                model_reset();
                check_all("arst");
            end
            if ($urandom_range(0, 3) == 0) begin
                a_v = $urandom;
                b_v = $urandom;
            end else begin
                a_v = a_v ^ ($urandom & $urandom & $urandom);
                b_v = b_v ^ ($urandom & $urandom & $urandom);
            end
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
